fetch_controller: RTL

//  Sequences the synchronous instruction memory for the 5-stage pipeline (IF stage).

---
 rtl/fetch_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch_controller.sv
// IF-stage sequencer: boots the start PC from memory, then issues one fetch per cycle.
// Optional out-of-range fetch trap enabled by defining FETCH_BOUND_CHECK_EN.
module fetch_controller #(
   parameter int Num_of_bits  = 16,
   parameter int pc_width     = 32,
   parameter int IMM_FLAG_BIT = 0,
   parameter int BOOT_ADDR    = 0,
   parameter int MEM_DEPTH    = 20
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [pc_width-1:0]    imem_pc,
   input  logic [Num_of_bits-1:0] imem_instr,
   input  logic [Num_of_bits-1:0] imem_imm,
   input  logic                   stall,
   input  logic                   redirect,
   input  logic [pc_width-1:0]    redirect_pc,
   output logic                   if_valid,
   output logic [Num_of_bits-1:0] if_instr,
   output logic [Num_of_bits-1:0] if_imm,
   output logic                   if_two_word,
   output logic [pc_width-1:0]    if_pc,
   output logic [pc_width-1:0]    if_pc_next,
   output logic                   fetch_fault
);

   localparam int BW = 2 * Num_of_bits;
   localparam logic [pc_width-1:0] BOOT_PC = pc_width'(BOOT_ADDR);

   typedef enum logic [1:0] {
      BOOT_REQ,
      BOOT_LOAD,
      RUN
`ifdef FETCH_BOUND_CHECK_EN
      , FAULT
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [pc_width-1:0] fetch_pc_q, fetch_pc_d;
   logic                pend_q, pend_d;
   logic [pc_width-1:0] start_pc, len, pc_sel;
   logic [BW-1:0]       boot_word;
   logic                two_raw, valid;

   assign boot_word = {imem_instr, imem_imm};
   generate
      if (pc_width <= BW) begin : g_trunc
         assign start_pc = boot_word[pc_width-1:0];
      end else begin : g_zext
         assign start_pc = {{(pc_width-BW){1'b0}}, boot_word};
      end
   endgenerate

   assign two_raw = imem_instr[IMM_FLAG_BIT];
   assign len     = {{(pc_width-2){1'b0}}, two_raw, ~two_raw};

`ifdef FETCH_BOUND_CHECK_EN
   localparam logic [pc_width-1:0] LAST_SLOT = pc_width'(MEM_DEPTH - 1);
   logic fault_q, fault_d;
`endif

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      pend_d     = pend_q;
      pc_sel     = fetch_pc_q;
      valid      = 1'b0;
`ifdef FETCH_BOUND_CHECK_EN
      fault_d    = fault_q;
`endif
      case (state_q)
         BOOT_REQ: begin
            pc_sel  = BOOT_PC;
            state_d = BOOT_LOAD;
         end
         BOOT_LOAD: begin
            pc_sel     = start_pc;
            fetch_pc_d = start_pc;
            pend_d     = 1'b1;
            state_d    = RUN;
         end
         RUN: begin
            if (redirect) begin
               pc_sel     = redirect_pc;
               fetch_pc_d = redirect_pc;
               pend_d     = 1'b1;
            end else if (stall) begin
               pc_sel = fetch_pc_q;
               valid  = pend_q;
            end else begin
               pc_sel     = fetch_pc_q + len;
               fetch_pc_d = pc_sel;
               valid      = pend_q;
            end
`ifdef FETCH_BOUND_CHECK_EN
            // Length of the next instruction is unknown, so reserve room for its immediate.
            if (pc_sel >= LAST_SLOT) begin
               fault_d = 1'b1;
               state_d = FAULT;
            end
`endif
         end
`ifdef FETCH_BOUND_CHECK_EN
         FAULT: pc_sel = fetch_pc_q;
`endif
         default: state_d = BOOT_REQ;
      endcase
      if (rst) begin
         pc_sel = BOOT_PC;
         valid  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BOOT_REQ;
         fetch_pc_q <= '0;
         pend_q     <= 1'b0;
`ifdef FETCH_BOUND_CHECK_EN
         fault_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pend_q     <= pend_d;
`ifdef FETCH_BOUND_CHECK_EN
         fault_q    <= fault_d;
`endif
      end
   end

   assign imem_pc     = pc_sel;
   assign if_valid    = valid;
   assign if_two_word = valid & two_raw;
   assign if_instr    = valid ? imem_instr : '0;
   assign if_imm      = if_two_word ? imem_imm : '0;
   assign if_pc       = fetch_pc_q;
   assign if_pc_next  = fetch_pc_q + {{(pc_width-2){1'b0}}, if_two_word, ~if_two_word};
`ifdef FETCH_BOUND_CHECK_EN
   assign fetch_fault = fault_q;
`else
   assign fetch_fault = 1'b0;
`endif

endmodule
